// File: rtl/auth_tag_tx.sv
// Transmit-side tagger: accepts a 32-bit word, folds it into a CRC-8 (poly 0x07) one byte
// per cycle, then holds word and tag for downstream. Optional: AUTH_TAG_TX_STALL_CNT_EN.
module auth_tag_tx #(
  parameter logic [7:0] TAG_INIT = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [7:0]  out_tag,
  output logic        busy
`ifdef AUTH_TAG_TX_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t      state, state_nxt;
  logic [1:0]  bcnt;
  logic [7:0]  crc;
  logic [7:0]  cur_byte;
  logic [7:0]  crc_step;
  logic        accept;

  // One full byte of the MSB-first CRC-8 recurrence, unrolled into combinational logic.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] data_byte);
    logic [7:0] c;
    c = crc_in ^ data_byte;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
  assign accept    = in_valid && in_ready;

  // The tag is computed from the latched copy, so input churn during CALC cannot leak in.
  always_comb begin
    cur_byte = out_data[31:24];
    case (bcnt)
      2'd0: cur_byte = out_data[31:24];
      2'd1: cur_byte = out_data[23:16];
      2'd2: cur_byte = out_data[15:8];
      2'd3: cur_byte = out_data[7:0];
      default: cur_byte = out_data[31:24];
    endcase
  end

  assign crc_step = crc8_byte(crc, cur_byte);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: if (bcnt == 2'd3) state_nxt = HOLD;
      HOLD: begin
        if (accept)         state_nxt = CALC;
        else if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= 32'h0;
      out_tag  <= 8'h00;
      crc      <= TAG_INIT;
      bcnt     <= 2'd0;
    end else if (accept) begin
      out_data <= in_data;
      crc      <= TAG_INIT;
      bcnt     <= 2'd0;
    end else if (state == CALC) begin
      crc  <= crc_step;
      bcnt <= bcnt + 2'd1;
      if (bcnt == 2'd3) out_tag <= crc_step;
    end
  end

`ifdef AUTH_TAG_TX_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= 16'h0000;
    else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'h0001;
  end
`endif

endmodule

// File: tb/tb_auth_tag_tx.sv
// Directed bench for auth_tag_tx: vector table of single words plus hand-written
// sequences for backpressure, back-to-back, input churn, mid-CALC reset and a random run.
module tb_auth_tag_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_tag;
  logic        busy;
`ifdef AUTH_TAG_TX_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  auth_tag_tx #(.TAG_INIT(8'h00)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag),
    .busy     (busy)
`ifdef AUTH_TAG_TX_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  tag;
  } vec_t;

  vec_t vecs[5];

  // Bit-serial reference: one polynomial step per message bit, MSB of the word first.
  function automatic logic [7:0] crc_ref(input logic [31:0] d);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 31; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Accept a word with out_ready low, then wait (bounded) for out_valid.
  task automatic accept_and_wait(input logic [31:0] d, input string name, input bit churn);
    int lat;
    in_data   = d;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    #1;
    check({name, "_in_ready_idle"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    in_data  = ~d;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      if (churn) in_data = $urandom;
      lat++;
    end
    check({name, "_latency"}, lat, 4);
  endtask

  task automatic run_word(input logic [31:0] d, input logic [7:0] tag, input string name);
    accept_and_wait(d, name, 1'b0);
    check({name, "_out_data"}, out_data, d);
    check({name, "_out_tag"}, out_tag, tag);
    check({name, "_in_ready_hold"}, in_ready, 0);
    check({name, "_busy_hold"}, busy, 1);
    out_ready = 1'b1;
    #1;
    check({name, "_in_ready_drain"}, in_ready, 1);
    step();
    out_ready = 1'b0;
    check({name, "_out_valid_clr"}, out_valid, 0);
    check({name, "_busy_clr"}, busy, 0);
  endtask

  logic [31:0] words[3];
  int          acc_cyc[3];
  logic [31:0] q[$];
  logic [31:0] exp_w;

  initial begin
    vecs[0] = '{data: 32'h00000001, tag: 8'h07};
    vecs[1] = '{data: 32'h01000000, tag: 8'h16};
    vecs[2] = '{data: 32'h00000000, tag: 8'h00};
    vecs[3] = '{data: 32'h00000002, tag: 8'h0E};
    vecs[4] = '{data: 32'h00000100, tag: 8'h15};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_busy", busy, 0);
`ifdef AUTH_TAG_TX_STALL_CNT_EN
    check("rst_stall_cnt", stall_cnt, 0);
`endif
    step();
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++)
      run_word(vecs[i].data, vecs[i].tag, $sformatf("vec%0d", i));

    // Backpressure: ten stalled cycles in HOLD.
    do_reset();
    accept_and_wait(32'h01000000, "bp", 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out_data, 32'h01000000);
      check("bp_out_tag", out_tag, 8'h16);
      check("bp_in_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_release", in_ready, 1);
`ifdef AUTH_TAG_TX_STALL_CNT_EN
    check("bp_stall_cnt", stall_cnt, 10);
`endif
    step();
    check("bp_out_valid_clr", out_valid, 0);
`ifdef AUTH_TAG_TX_STALL_CNT_EN
    check("bp_stall_cnt_after", stall_cnt, 10);
`endif
    out_ready = 1'b0;

    // Back-to-back with in_valid and out_ready held high.
    begin
      int widx, oidx, cyc;
      words[0] = 32'hDEADBEEF; words[1] = 32'h12345678; words[2] = 32'h00000001;
      widx = 0; oidx = 0; cyc = 0;
      in_data = words[0]; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      while (oidx < 3 && cyc < 60) begin
        if (out_valid && out_ready) begin
          check($sformatf("b2b_data%0d", oidx), out_data, words[oidx]);
          check($sformatf("b2b_tag%0d", oidx), out_tag, crc_ref(words[oidx]));
          oidx++;
        end
        if (in_valid && in_ready) begin
          acc_cyc[widx] = cyc;
          widx++;
        end
        step();
        cyc++;
        if (widx < 3) in_data = words[widx];
        else          in_valid = 1'b0;
        #1;
      end
      check("b2b_outputs", oidx, 3);
      check("b2b_accepts", widx, 3);
      check("b2b_gap01", acc_cyc[1] - acc_cyc[0], 5);
      check("b2b_gap12", acc_cyc[2] - acc_cyc[1], 5);
      step();
      step();
      check("b2b_no_extra", out_valid, 0);
      out_ready = 1'b0;
    end

    // Input churn during CALC.
    accept_and_wait(32'hA5C3_0F96, "churn", 1'b1);
    check("churn_data", out_data, 32'hA5C3_0F96);
    check("churn_tag", out_tag, crc_ref(32'hA5C3_0F96));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset asserted mid-CALC.
    in_data = 32'h00000001; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_tag", out_tag, 0);
    check("midrst_busy", busy, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("midrst_no_valid", out_valid, 0);
    check("midrst_in_ready_after", in_ready, 1);

    // Random traffic against the reference model.
    begin
      int sent, got, cyc;
      sent = 0; got = 0; cyc = 0;
      while (got < 1000 && cyc < 20000) begin
        in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
        in_data   = $urandom;
        out_ready = ($urandom_range(0, 1) == 1);
        #1;
        if (in_valid && in_ready) begin
          q.push_back(in_data);
          sent++;
        end
        if (out_valid && out_ready) begin
          check("rand_pending", q.size() != 0, 1);
          if (q.size() != 0) begin
            exp_w = q.pop_front();
            check("rand_data", out_data, exp_w);
            check("rand_tag", out_tag, crc_ref(exp_w));
          end
          got++;
        end
        step();
        cyc++;
      end
      check("rand_received", got, 1000);
      check("rand_sent", sent, 1000);
      in_valid = 1'b0;
      out_ready = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/auth_tag_tx.md
# auth_tag_tx

Transmit-side companion of the tag authenticator. It accepts 32-bit words over a valid/ready handshake and computes an 8-bit CRC-8 tag over the word serially, one byte per cycle. It then presents the word and its tag downstream, where the authenticator regenerates the tag, compares it and gates the data. Tag function: CRC-8, polynomial 0x07, MSB-first, no reflection, no final XOR; bytes are processed `[31:24]` first.

## Interface
- `TAG_INIT`, 8'h00, CRC register initial value loaded at each accepted word.
- `clk`  input  1  single clock; all state on rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `in_valid`  input  1  upstream word valid.
- `in_ready`  output  1  block can accept a word this cycle.
- `in_data`  input  32  word to tag.
- `out_valid`  output  1  `out_data`/`out_tag` valid.
- `out_ready`  input  1  downstream accepts this cycle.
- `out_data`  output  32  registered copy of accepted word.
- `out_tag`  output  8  CRC-8 of `out_data`.
- `busy`  output  1  high in CALC or HOLD.

## Operation
- States:
  - IDLE: waiting for a word.
  - CALC: 2-bit byte counter `bcnt` runs 0..3.
  - HOLD: output presented.
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0, `out_tag`=0, `busy`=0, `bcnt`=0, CRC register = `TAG_INIT`.
- Accept: `in_valid && in_ready` at an edge.
  - Latches `in_data` into `out_data`.
  - Loads CRC = `TAG_INIT` and `bcnt` = 0.
  - Goes to CALC.
- CALC, each cycle: CRC = table(CRC ^ byte[bcnt]).
  - byte[0]=`[31:24]` … byte[3]=`[7:0]`.
  - Table step: 8 iterations of shift-left, XOR 0x07 when the bit shifted out is 1. This is combinational within one cycle.
  - When `bcnt`==3: write the result to `out_tag`, set `out_valid`, go to HOLD.
- HOLD:
  - `out_data`/`out_tag` stay stable while `out_valid && !out_ready`.
  - On `out_ready`, clear `out_valid` and go to IDLE, unless a new word is accepted on the same edge.
- `in_ready` = (state==IDLE) || (state==HOLD && `out_ready`).
  - A simultaneous output handshake and input accept in HOLD goes directly to CALC with the new word.
  - `out_valid` deasserts on that edge.
- `in_data` is ignored outside an accept edge. Changes to the input during CALC do not affect the tag.
- `in_valid` dropping without a handshake is legal and has no effect.
- Reset asserted mid-CALC or mid-HOLD: returns immediately to the reset values and discards the in-flight word.

## Timing
- Accept at edge N → CALC during N+1..N+4 → `out_valid`=1 after edge N+4.
- Latency from accept to `out_valid`: 4 cycles.
- With `out_ready` held high, sustained throughput is one word per 5 cycles: output handshake and next accept share an edge.
- Backpressure: HOLD persists indefinitely, and `in_ready`=0 throughout it.
- No combinational path from `in_valid` to any output.
- `in_ready` depends combinationally on `out_ready` in HOLD only.

## Configuration
- `AUTH_TAG_TX_STALL_CNT_EN`
  - Defined: adds output `stall_cnt` (16-bit). It increments on each cycle with `out_valid && !out_ready`, saturates at 16'hFFFF, and resets to 0 only on `rst_n`.
  - Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset: assert `rst_n`=0 mid-CALC → next sample shows all outputs at reset values, `in_ready`=1, no `out_valid` after release.
- Single word, `TAG_INIT`=0:
  - `in_data`=32'h00000001 → after 4 cycles `out_valid`=1, `out_data`=32'h00000001, `out_tag`=8'h07.
  - `in_data`=32'h01000000 → `out_tag`=8'h16.
  - `in_data`=0 → `out_tag`=8'h00.
- Backpressure: `out_ready`=0 for 10 cycles in HOLD.
  - Outputs stable and `in_ready`=0 throughout.
  - Handshake occurs on the first `out_ready`=1 cycle.
  - With macro enabled, `stall_cnt`=10.
- Back-to-back: `in_valid` and `out_ready` held high with 3 words → accepts every 5 cycles, tags correct for each, no word lost or duplicated.
- Input churn: `in_data` toggled every cycle during CALC → tag matches the word latched at accept.
- Random: 1000 words with random `in_valid`/`out_ready` → every output pair matches a reference CRC-8 model, in order.
